// File: rtl/urv_imem_pkg.sv
// urv_imem_pkg: shared definitions for the uRV instruction-memory responder.
// Holds the FSM state encoding, line geometry helpers and the line-base helper.
package urv_imem_pkg;

    // Responder FSM states (legacy-compatible constant encoding).
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Widest byte address the line-base helper can handle.
    localparam int MAX_ADDR_W = 64;

    // Word-offset width inside a line (LINE_WORDS is a power of two).
    function automatic int offset_w(input int line_words);
        return $clog2(line_words);
    endfunction

    // Tag width: everything above the word offset and the two byte-lane bits.
    function automatic int tag_w(input int addr_w, input int line_words);
        return addr_w - $clog2(line_words) - 2;
    endfunction

    // Byte address of the first word of the line containing addr.
    function automatic logic [MAX_ADDR_W-1:0] line_base(input logic [MAX_ADDR_W-1:0] addr,
                                                        input int line_words);
        logic [MAX_ADDR_W-1:0] line_bytes;
        line_bytes = MAX_ADDR_W'(line_words) << 2;
        return addr & ~(line_bytes - MAX_ADDR_W'(1));
    endfunction

endpackage

// File: rtl/urv_imem_line_buf.sv
// urv_imem_line_buf: the single instruction line of the responder.
// LINE_WORDS x 32 storage with one synchronous write port (refill) and one
// combinational read port (lookup), plus the line tag and valid bit.
module urv_imem_line_buf
    import urv_imem_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int TAG_W      = 28
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            we,
    input  logic [offset_w(LINE_WORDS)-1:0] wr_offset,
    input  logic [31:0]                     wr_data,
    input  logic [offset_w(LINE_WORDS)-1:0] rd_offset,
    output logic [31:0]                     rd_data,
    input  logic                            tag_we,
    input  logic [TAG_W-1:0]                tag_d,
    output logic [TAG_W-1:0]                tag,
    input  logic                            valid_we,
    input  logic                            valid_d,
    output logic                            valid
);

    logic [31:0] words [LINE_WORDS];

    // Refill writes land in the word array one word per backing-bus ack.
    // NOTE: the array has no reset; the valid bit alone says whether its contents mean anything, so it can map onto plain storage.
    // NOTE: sequential state is always assigned with <= so every flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (we) begin
            words[wr_offset] <= wr_data;
        end
    end

    assign rd_data = words[rd_offset];

    // Tag and valid bit; reset drops valid so a partial or stale line never hits.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tag   <= '0;
            valid <= 1'b0;
        end else begin
            if (tag_we) begin
                tag <= tag_d;
            end
            if (valid_we) begin
                valid <= valid_d;
            end
        end
    end

endmodule

// File: rtl/urv_imem_responder.sv
// urv_imem_responder: fetch-side instruction-memory responder for uRV.
// A one-line instruction buffer answers hits one cycle after the address is
// sampled; misses refill the whole line over a word-wide req/ack backing bus.
// Optional feature macro: URV_IMEM_CRITICAL_WORD_FIRST_EN -- fill starts at the
// missed word and that word is returned as soon as it arrives.
module urv_imem_responder
    import urv_imem_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] im_addr_i,
    output logic [31:0]       im_data_o,
    output logic              im_valid_o,
    input  logic              inv_i,
    output logic              busy_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [31:0]       mem_data_i,
    input  logic              mem_ack_i
);

    localparam int OFFSET_W = offset_w(LINE_WORDS);
    localparam int TAG_W    = tag_w(ADDR_W, LINE_WORDS);
    localparam int TAG_LSB  = OFFSET_W + 2;
    localparam logic [OFFSET_W-1:0] LAST_WORD = OFFSET_W'(LINE_WORDS - 1);

    logic [1:0]          state;
    logic [OFFSET_W-1:0] count;
    logic                pending_inv;

    // Lookup fields of the requested address.
    logic [TAG_W-1:0]    req_tag;
    logic [OFFSET_W-1:0] req_offset;
    assign req_tag    = im_addr_i[ADDR_W-1:TAG_LSB];
    assign req_offset = im_addr_i[TAG_LSB-1:2];

    // Byte-lane bits carry no meaning for word fetches; fold them into a sink.
    logic unused_addr_lanes;
    assign unused_addr_lanes = ^im_addr_i[1:0];

    // Current position of the refill inside the line; the tag part never changes.
    logic [OFFSET_W-1:0] fill_offset;
    logic [OFFSET_W-1:0] next_offset;
    assign fill_offset = mem_addr_o[TAG_LSB-1:2];
    assign next_offset = fill_offset + OFFSET_W'(1);

    // Line buffer interface.
    logic [31:0]      rd_data;
    logic [TAG_W-1:0] line_tag;
    logic             line_valid;
    logic             buf_we;
    logic             tag_we;
    logic             valid_we;
    logic             valid_d;

    urv_imem_line_buf #(
        .LINE_WORDS (LINE_WORDS),
        .TAG_W      (TAG_W)
    ) u_line_buf (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .we        (buf_we),
        .wr_offset (fill_offset),
        .wr_data   (mem_data_i),
        .rd_offset (req_offset),
        .rd_data   (rd_data),
        .tag_we    (tag_we),
        .tag_d     (req_tag),
        .tag       (line_tag),
        .valid_we  (valid_we),
        .valid_d   (valid_d),
        .valid     (line_valid)
    );

    // A hit is only possible while idle; during a refill nothing is looked up.
    logic hit;
    assign hit = line_valid && (line_tag == req_tag) && (state == S_IDLE);

    assign busy_o = (state != S_IDLE);

    // First backing-bus address of a refill triggered by the current request.
    logic [ADDR_W-1:0] first_fill_addr;
`ifdef URV_IMEM_CRITICAL_WORD_FIRST_EN
    assign first_fill_addr = {im_addr_i[ADDR_W-1:2], 2'b00};

    // Word address of the request that caused the current refill.
    logic [ADDR_W-3:0] miss_word;
`else
    assign first_fill_addr = ADDR_W'(line_base(MAX_ADDR_W'(im_addr_i), LINE_WORDS));
`endif

    // Line-buffer write, tag and valid controls derived from the FSM state.
    // NOTE: every output gets a default at the top so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        buf_we   = 1'b0;
        tag_we   = 1'b0;
        valid_we = 1'b0;
        valid_d  = 1'b0;
        case (state)
            S_IDLE: begin
                if (inv_i) begin
                    valid_we = 1'b1;
                end else if (!hit) begin
                    // Miss: claim the line for the new tag and drop it until refilled.
                    tag_we   = 1'b1;
                    valid_we = 1'b1;
                end
            end
            S_FILL: begin
                buf_we = mem_ack_i;
            end
            S_DONE: begin
                // An invalidate seen at any point of the refill keeps the line dead.
                valid_we = 1'b1;
                valid_d  = !(pending_inv || inv_i);
            end
            default: begin
            end
        endcase
    end

    // Responder FSM: lookup/response in S_IDLE, req/ack refill in S_FILL, commit in S_DONE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            count       <= '0;
            pending_inv <= 1'b0;
            im_data_o   <= '0;
            im_valid_o  <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_addr_o  <= '0;
`ifdef URV_IMEM_CRITICAL_WORD_FIRST_EN
            miss_word   <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (inv_i) begin
                        // Invalidate wins over a hit on the same edge.
                        im_valid_o <= 1'b0;
                    end else if (hit) begin
                        im_data_o  <= rd_data;
                        im_valid_o <= 1'b1;
                    end else begin
                        im_valid_o <= 1'b0;
                        state      <= S_FILL;
                        mem_req_o  <= 1'b1;
                        mem_addr_o <= first_fill_addr;
                        count      <= '0;
`ifdef URV_IMEM_CRITICAL_WORD_FIRST_EN
                        miss_word  <= im_addr_i[ADDR_W-1:2];
`endif
                    end
                end

                S_FILL: begin
                    im_valid_o <= 1'b0;
                    if (inv_i) begin
                        pending_inv <= 1'b1;
                    end
                    if (mem_ack_i) begin
                        // Offset wraps inside the line; the tag bits are never incremented.
                        mem_addr_o <= {mem_addr_o[ADDR_W-1:TAG_LSB], next_offset, 2'b00};
                        count      <= count + OFFSET_W'(1);
`ifdef URV_IMEM_CRITICAL_WORD_FIRST_EN
                        // The first word fetched is the missed one; forward it if fetch still wants it.
                        if ((count == '0) && (im_addr_i[ADDR_W-1:2] == miss_word)) begin
                            im_data_o  <= mem_data_i;
                            im_valid_o <= 1'b1;
                        end
`endif
                        if (count == LAST_WORD) begin
                            mem_req_o <= 1'b0;
                            state     <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    im_valid_o  <= 1'b0;
                    pending_inv <= 1'b0;
                    state       <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_urv_imem_responder.sv
// tb_urv_imem_responder: directed scenarios plus randomized fetch traffic for
// urv_imem_responder, checked against a transaction-level reference model.
module tb_urv_imem_responder;

    localparam int LW = 4;
    localparam int AW = 32;
`ifdef URV_IMEM_CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [AW-1:0] im_addr_i;
    logic [31:0]   im_data_o;
    logic          im_valid_o;
    logic          inv_i;
    logic          busy_o;
    logic          mem_req_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_data_i;
    logic          mem_ack_i;

    always #5 clk_i = ~clk_i;

    urv_imem_responder #(
        .LINE_WORDS (LW),
        .ADDR_W     (AW)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .im_addr_i  (im_addr_i),
        .im_data_o  (im_data_o),
        .im_valid_o (im_valid_o),
        .inv_i      (inv_i),
        .busy_o     (busy_o),
        .mem_req_o  (mem_req_o),
        .mem_addr_o (mem_addr_o),
        .mem_data_i (mem_data_i),
        .mem_ack_i  (mem_ack_i)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model (line-level view) ----------------
    bit          res_valid = 1'b0;   // line holds backing-memory contents of res_base
    logic [31:0] res_base  = '0;
    int          fill_left = 0;      // words still to arrive for the current refill
    bit          done_wait = 1'b0;   // refill finished, commit cycle pending
    bit          inv_pend  = 1'b0;
    logic [31:0] miss_addr = '0;
    logic [31:0] fill_q[$];          // expected backing-bus addresses, in order
    bit          exp_valid = 1'b0;
    logic [31:0] exp_data  = '0;
    int          hs_seen   = 0;      // req&ack handshakes observed on the DUT

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a & ~32'h3) ^ 32'hA5A5A5A5;
    endfunction

    function automatic logic [31:0] base_of(input logic [31:0] a);
        return a & ~32'(LW * 4 - 1);
    endfunction

    function automatic bit model_idle();
        return (fill_left == 0) && !done_wait;
    endfunction

    // Advance the model across one clock edge with the given inputs.
    task automatic model_edge(input logic [31:0] a, input bit inv, input bit ack);
        int start;
        exp_valid = 1'b0;
        if (fill_left > 0) begin
            if (inv) inv_pend = 1'b1;
            if (ack) begin
                void'(fill_q.pop_front());
                if (CWF && fill_left == LW && a[31:2] == miss_addr[31:2]) begin
                    exp_valid = 1'b1;
                    exp_data  = mem_word(miss_addr);
                end
                fill_left--;
                if (fill_left == 0) done_wait = 1'b1;
            end
        end else if (done_wait) begin
            res_valid = !(inv_pend || inv);
            inv_pend  = 1'b0;
            done_wait = 1'b0;
        end else if (inv) begin
            res_valid = 1'b0;
        end else if (res_valid && base_of(a) == res_base) begin
            exp_valid = 1'b1;
            exp_data  = mem_word(a);
        end else begin
            res_valid = 1'b0;
            res_base  = base_of(a);
            miss_addr = a;
            fill_left = LW;
            fill_q.delete();
            start = CWF ? int'((a - res_base) >> 2) : 0;
            for (int k = 0; k < LW; k++) begin
                fill_q.push_back(res_base + 32'(((start + k) % LW) * 4));
            end
        end
    endtask

    task automatic compare();
        check("im_valid", 32'(im_valid_o), 32'(exp_valid));
        if (exp_valid) check("im_data", im_data_o, exp_data);
        check("mem_req", 32'(mem_req_o), 32'(fill_left > 0));
        if (fill_left > 0) check("mem_addr", mem_addr_o, fill_q[0]);
        check("busy", 32'(busy_o), 32'(!model_idle()));
    endtask

    // One clock: drive at negedge, model the edge, compare at the next negedge.
    task automatic step(input logic [31:0] a, input bit inv, input bit ack_ok);
        bit do_ack;
        do_ack     = (fill_left > 0) && ack_ok;
        im_addr_i  = a;
        inv_i      = inv;
        mem_ack_i  = 1'b0;
        mem_data_i = $urandom;
        if (do_ack) begin
            mem_ack_i  = 1'b1;
            mem_data_i = mem_word(fill_q[0]);
        end else if (fill_left == 0 && $urandom_range(0, 3) == 0) begin
            mem_ack_i = 1'b1;  // stray ack outside a refill
        end
        if (mem_req_o && mem_ack_i) hs_seen++;
        model_edge(a, inv, do_ack);
        @(posedge clk_i);
        @(negedge clk_i);
        compare();
    endtask

    // Hold an address until it is served (bounded), as the fetch stage does.
    task automatic serve(input logic [31:0] a, output int n);
        n = 0;
        do begin
            step(a, 1'b0, 1'b1);
            n++;
        end while (!exp_valid && n < 100);
        check("served", 32'(im_valid_o), 32'd1);
    endtask

    // Keep presenting an address until any refill in flight is committed.
    task automatic drain(input logic [31:0] a);
        int n = 0;
        while (!model_idle() && n < 100) begin
            step(a, 1'b0, 1'b1);
            n++;
        end
        check("drained", 32'(busy_o), 32'd0);
    endtask

    task automatic model_reset();
        res_valid = 1'b0;
        fill_left = 0;
        done_wait = 1'b0;
        inv_pend  = 1'b0;
        exp_valid = 1'b0;
        fill_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   32'(mem_req_o),  32'd0);
        check({tag, "_valid"}, 32'(im_valid_o), 32'd0);
        check({tag, "_busy"},  32'(busy_o),     32'd0);
        check({tag, "_data"},  im_data_o,       32'd0);
        check({tag, "_maddr"}, mem_addr_o,      32'd0);
    endtask

    initial begin
        int          n;
        int          hs0;
        logic [31:0] a;
        logic [31:0] first;
        logic [31:0] lines [4];

        rst_i      = 1'b1;
        im_addr_i  = '0;
        inv_i      = 1'b0;
        mem_data_i = '0;
        mem_ack_i  = 1'b0;
        repeat (2) @(negedge clk_i);
        check_reset_outputs("reset");
        rst_i = 1'b0;

        // Cold miss at 0x100, acks every cycle.
        serve(32'h100, n);
        check("cold_data", im_data_o, 32'hA5A5A4A5);
        check("miss_latency", 32'(n), CWF ? 32'd2 : 32'(LW + 3));
        drain(32'h100);

        // Back-to-back sequential hits.
        for (int i = 0; i < LW; i++) begin
            step(32'h100 + 32'(i * 4), 1'b0, 1'b1);
            check("seq_hit", 32'(im_valid_o), 32'd1);
            check("seq_noreq", 32'(mem_req_o), 32'd0);
        end

        // Branch to 0x204 after two acks of the 0x100 refill.
        step(32'h100, 1'b1, 1'b1);
        hs0 = hs_seen;
        step(32'h100, 1'b0, 1'b1);
        step(32'h100, 1'b0, 1'b1);
        step(32'h100, 1'b0, 1'b1);
        serve(32'h204, n);
        drain(32'h204);
        check("branch_handshakes", 32'(hs_seen - hs0), 32'd8);
        step(32'h108, 1'b0, 1'b1);
        check("branch_remiss", 32'(mem_req_o), 32'd1);
        drain(32'h108);

        // Invalidate in the middle of a refill: line must be fetched again.
        step(32'h100, 1'b1, 1'b1);
        hs0 = hs_seen;
        step(32'h100, 1'b0, 1'b1);
        step(32'h100, 1'b0, 1'b1);
        step(32'h100, 1'b1, 1'b1);
        serve(32'h100, n);
        drain(32'h100);
        check("inv_refetch", 32'(hs_seen - hs0), 32'd8);

        // Miss at 0x10C with a 3-cycle ack stall.
        step(32'h10C, 1'b1, 1'b1);
        step(32'h10C, 1'b0, 1'b1);
        first = CWF ? 32'h10C : 32'h100;
        check("first_fill_addr", mem_addr_o, first);
        for (int i = 0; i < 3; i++) begin
            step(32'h10C, 1'b0, 1'b0);
            check("stall_req", 32'(mem_req_o), 32'd1);
            check("stall_addr", mem_addr_o, first);
        end
        serve(32'h10C, n);
        drain(32'h10C);

        // Reset with two of four words received.
        step(32'h100, 1'b1, 1'b1);
        step(32'h100, 1'b0, 1'b1);
        step(32'h100, 1'b0, 1'b1);
        step(32'h100, 1'b0, 1'b1);
        mem_ack_i = 1'b0;
        inv_i     = 1'b0;
        rst_i     = 1'b1;
        #1;
        check("midfill_rst_req", 32'(mem_req_o), 32'd0);
        check("midfill_rst_valid", 32'(im_valid_o), 32'd0);
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        step(32'h100, 1'b0, 1'b1);
        check("post_reset_miss", 32'(mem_req_o), 32'd1);
        drain(32'h100);

        // Line at the top of the address space.
        serve(32'hFFFF_FFF8, n);
        drain(32'hFFFF_FFF8);
        step(32'hFFFF_FFFC, 1'b0, 1'b1);
        check("top_hit", im_data_o, 32'hFFFF_FFFC ^ 32'hA5A5A5A5);

        // Randomized fetch traffic: sequential runs, jumps, branches mid-miss,
        // invalidates, ack stalls, stray acks and junk byte-lane bits.
        lines[0] = 32'h0000_0100;
        lines[1] = 32'h0000_0200;
        lines[2] = 32'h0000_0000;
        lines[3] = 32'hFFFF_FFF0;
        a = 32'h100;
        for (int i = 0; i < 1500; i++) begin
            step(a | 32'($urandom_range(0, 3)),
                 $urandom_range(0, 39) == 0,
                 $urandom_range(0, 3) != 0);
            if (exp_valid || $urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4: a = a + 32'd4;
                    5, 6, 7:       a = lines[$urandom_range(0, 3)] + 32'($urandom_range(0, LW - 1) * 4);
                    default:       a = a;
                endcase
            end
        end
        drain(a);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
